// File: rtl/bist_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : bist_response_checker
// Brief    : Read-side checker for the SRAM BIST. Delays each issued read's
//            address/expected word until the SRAM returns data, compares,
//            and accumulates pass/fail, error count and first-fail details.
// Revision : 1.0 - initial release
// ============================================================================
module bist_response_checker #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 4,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [DATA_WIDTH-1:0]    exp_data,
    input  logic                     last,
    input  logic [DATA_WIDTH-1:0]    sram_dout,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_fail_addr,
    output logic [DATA_WIDTH-1:0]    first_fail_syn
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Drain counter only needs to hold READ_LATENCY (at most 4).
    localparam logic [2:0] c_LAT = 3'(READ_LATENCY);

    state_t                    r_state;
    logic [2:0]                r_drain_cnt;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_fail;
    logic [ERR_CNT_WIDTH-1:0]  r_err_count;
    logic [ADDR_WIDTH-1:0]     r_ff_addr;
    logic [DATA_WIDTH-1:0]     r_ff_syn;

    // Alignment pipeline: stage READ_LATENCY-1 lines up with sram_dout.
    logic                      r_pv [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]     r_pa [READ_LATENCY];
    logic [DATA_WIDTH-1:0]     r_pe [READ_LATENCY];

    logic                      w_accept;
    logic                      w_start_go;
    logic                      w_tail_v;
    logic [ADDR_WIDTH-1:0]     w_tail_addr;
    logic [DATA_WIDTH-1:0]     w_syn;
    logic                      w_mismatch;

    // A read is only taken while checking; start only acts from IDLE/DONE.
    assign w_accept    = (r_state == ST_CHECK) && rd_en;
    assign w_start_go  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    assign w_tail_v    = r_pv[READ_LATENCY-1];
    assign w_tail_addr = r_pa[READ_LATENCY-1];
    assign w_syn       = sram_dout ^ r_pe[READ_LATENCY-1];
    assign w_mismatch  = w_tail_v && (|w_syn);

    // Shift the {valid, addr, exp} tags every cycle; reset flushes valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= '0;
                r_pe[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pa[0] <= rd_addr;
            r_pe[0] <= exp_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    // Control FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CHECK;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (rd_en && last) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= c_LAT;
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt - 3'd1;
                    // Last compare lands on this same edge.
                    if (r_drain_cnt == 3'd1) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_state <= ST_CHECK;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Result accumulation: cleared by a new pass, first failure is sticky.
    always_ff @(posedge clk) begin
        if (rst || w_start_go) begin
            r_fail      <= 1'b0;
            r_err_count <= '0;
            r_ff_addr   <= '0;
            r_ff_syn    <= '0;
        end else if (w_mismatch) begin
            r_fail <= 1'b1;
            if (r_err_count != {ERR_CNT_WIDTH{1'b1}}) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (!r_fail) begin
                r_ff_addr <= w_tail_addr;
                r_ff_syn  <= w_syn;
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign fail            = r_fail;
    assign err_count       = r_err_count;
    assign first_fail_addr = r_ff_addr;
    assign first_fail_syn  = r_ff_syn;

endmodule
`default_nettype wire
